// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : game_flow_ctrl
// Brief   : Multi-level game-flow FSM with pause, countdown timer, lives and
//           level index; drives one-hot status and HUD counters.
// Revision: 1.0 - initial release
// ============================================================================
module game_flow_ctrl #(
    parameter int          NUM_LEVELS = 3,
    parameter int          NUM_LIVES  = 3,
    parameter int          TIME_LIMIT = 1800,
    parameter logic [7:0]  KEY_START  = 8'h28,
    parameter logic [7:0]  KEY_PAUSE  = 8'h13,
    parameter logic [7:0]  KEY_QUIT   = 8'h29,
    localparam int         LW         = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int         LVW        = $clog2(NUM_LIVES + 1),
    localparam int         TW         = $clog2(TIME_LIMIT + 1)
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [7:0]     keycode,
    input  logic           frame_tick,
    input  logic           level_clear,
    input  logic           player_dead,
    output logic [5:0]     status,
    output logic [LW-1:0]  level,
    output logic [LVW-1:0] lives,
    output logic [TW-1:0]  timer,
    output logic           level_start
);

    typedef enum logic [2:0] {
        S_TITLE      = 3'd0,
        S_PLAY       = 3'd1,
        S_LEVEL_DONE = 3'd2,
        S_WIN        = 3'd3,
        S_LOSE       = 3'd4,
        S_PAUSE      = 3'd5
    } state_t;

    localparam logic [LW-1:0]  LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [LVW-1:0] LIVES_INIT = LVW'(NUM_LIVES);
    localparam logic [TW-1:0]  TIMER_INIT = TW'(TIME_LIMIT);

    state_t         state_q, state_d;
    logic [LW-1:0]  level_q, level_d;
    logic [LVW-1:0] lives_q, lives_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           level_start_q, level_start_d;
    logic [7:0]     prev_key_q;

    logic start_edge, pause_edge, quit_edge;

    // Keys act on the press edge only; holding a key never retriggers.
    assign start_edge = (keycode == KEY_START) && (prev_key_q != KEY_START);
    assign pause_edge = (keycode == KEY_PAUSE) && (prev_key_q != KEY_PAUSE);
    assign quit_edge  = (keycode == KEY_QUIT)  && (prev_key_q != KEY_QUIT);

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        lives_d       = lives_q;
        timer_d       = timer_q;
        level_start_d = 1'b0;
        case (state_q)
            S_TITLE: begin
                if (start_edge) begin
                    state_d       = S_PLAY;
                    level_d       = '0;
                    lives_d       = LIVES_INIT;
                    timer_d       = TIMER_INIT;
                    level_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (level_clear) begin
                    state_d = (level_q == LAST_LEVEL) ? S_WIN : S_LEVEL_DONE;
                end else if (player_dead || (timer_q == '0)) begin
                    lives_d = lives_q - LVW'(1);
                    if (lives_q == LVW'(1)) begin
                        state_d = S_LOSE;
                    end else begin
                        timer_d       = TIMER_INIT;
                        level_start_d = 1'b1;
                    end
                end else if (pause_edge) begin
                    state_d = S_PAUSE;
                end else if (frame_tick && (timer_q != '0)) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_PAUSE: begin
                if (quit_edge) begin
                    state_d = S_TITLE;
                end else if (pause_edge) begin
                    state_d = S_PLAY;
                end
            end
            S_LEVEL_DONE: begin
                if (start_edge) begin
                    state_d       = S_PLAY;
                    level_d       = level_q + LW'(1);
                    timer_d       = TIMER_INIT;
                    level_start_d = 1'b1;
                end
            end
            S_WIN, S_LOSE: begin
                if (start_edge) begin
                    state_d = S_TITLE;
                end
            end
            default: begin
                state_d = S_TITLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_TITLE;
            level_q       <= '0;
            lives_q       <= LIVES_INIT;
            timer_q       <= TIMER_INIT;
            level_start_q <= 1'b0;
            prev_key_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            level_start_q <= level_start_d;
            prev_key_q    <= keycode;
        end
    end

    // Bit order {PAUSE, LOSE, WIN, LEVEL_DONE, PLAY, TITLE}; illegal codes show all-zero.
    always_comb begin
        status = 6'b000000;
        case (state_q)
            S_TITLE:      status = 6'b000001;
            S_PLAY:       status = 6'b000010;
            S_LEVEL_DONE: status = 6'b000100;
            S_WIN:        status = 6'b001000;
            S_LOSE:       status = 6'b010000;
            S_PAUSE:      status = 6'b100000;
            default:      status = 6'b000000;
        endcase
    end

    assign level       = level_q;
    assign lives       = lives_q;
    assign timer       = timer_q;
    assign level_start = level_start_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_flow_ctrl
// Brief   : Scoreboard bench for game_flow_ctrl: directed scenarios followed by
//           random key/event traffic, checked against a rule-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_game_flow_ctrl;

    localparam int         NUM_LEVELS = 3;
    localparam int         NUM_LIVES  = 3;
    localparam int         TIME_LIMIT = 4;
    localparam logic [7:0] K_START    = 8'h28;
    localparam logic [7:0] K_PAUSE    = 8'h13;
    localparam logic [7:0] K_QUIT     = 8'h29;
    localparam int         LW         = 2;
    localparam int         LVW        = 2;
    localparam int         TW         = 3;

    // Model modes double as the one-hot status bit index.
    localparam int M_TITLE = 0, M_PLAY = 1, M_DONE = 2, M_WIN = 3, M_LOSE = 4, M_PAUSE = 5;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b1;
    logic [7:0]     keycode = 8'h00;
    logic           frame_tick = 1'b0;
    logic           level_clear = 1'b0;
    logic           player_dead = 1'b0;
    logic [5:0]     status;
    logic [LW-1:0]  level;
    logic [LVW-1:0] lives;
    logic [TW-1:0]  timer;
    logic           level_start;

    game_flow_ctrl #(
        .NUM_LEVELS (NUM_LEVELS),
        .NUM_LIVES  (NUM_LIVES),
        .TIME_LIMIT (TIME_LIMIT),
        .KEY_START  (K_START),
        .KEY_PAUSE  (K_PAUSE),
        .KEY_QUIT   (K_QUIT)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .frame_tick  (frame_tick),
        .level_clear (level_clear),
        .player_dead (player_dead),
        .status      (status),
        .level       (level),
        .lives       (lives),
        .timer       (timer),
        .level_start (level_start)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int status;
        int level;
        int lives;
        int timer;
        int ls;
    } exp_t;

    exp_t q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    int m_mode, m_level, m_lives, m_timer, m_ls, m_prev;

    function automatic void model_reset();
        m_mode = M_TITLE; m_level = 0; m_lives = NUM_LIVES;
        m_timer = TIME_LIMIT; m_ls = 0; m_prev = 0;
    endfunction

    function automatic void model_step(input bit rst_n, input int key,
                                       input bit tick, input bit clr, input bit dead);
        bit e_start, e_pause, e_quit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_start = (key == K_START) && (m_prev != K_START);
        e_pause = (key == K_PAUSE) && (m_prev != K_PAUSE);
        e_quit  = (key == K_QUIT)  && (m_prev != K_QUIT);
        m_prev  = key;
        m_ls    = 0;
        if (m_mode == M_TITLE && e_start) begin
            m_mode = M_PLAY; m_level = 0; m_lives = NUM_LIVES; m_timer = TIME_LIMIT; m_ls = 1;
        end else if (m_mode == M_PLAY) begin
            if (clr) begin
                m_mode = (m_level == NUM_LEVELS - 1) ? M_WIN : M_DONE;
            end else if (dead || m_timer == 0) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) m_mode = M_LOSE;
                else begin m_timer = TIME_LIMIT; m_ls = 1; end
            end else if (e_pause) begin
                m_mode = M_PAUSE;
            end else if (tick && m_timer > 0) begin
                m_timer = m_timer - 1;
            end
        end else if (m_mode == M_PAUSE) begin
            if (e_quit) m_mode = M_TITLE;
            else if (e_pause) m_mode = M_PLAY;
        end else if (m_mode == M_DONE && e_start) begin
            m_mode = M_PLAY; m_level = m_level + 1; m_timer = TIME_LIMIT; m_ls = 1;
        end else if ((m_mode == M_WIN || m_mode == M_LOSE) && e_start) begin
            m_mode = M_TITLE;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.status = 1 << m_mode;
        e.level  = m_level;
        e.lives  = m_lives;
        e.timer  = m_timer;
        e.ls     = m_ls;
        return e;
    endfunction

    function automatic void compare(input string name, input exp_t e);
        vec_cnt++;
        if (int'(status) != e.status || int'(level) != e.level || int'(lives) != e.lives ||
            int'(timer) != e.timer || int'(level_start) != e.ls) begin
            err_cnt++;
            $display("FAIL %s #%0d: got status=%b level=%0d lives=%0d timer=%0d ls=%0d, exp status=%b level=%0d lives=%0d timer=%0d ls=%0d",
                     name, vec_cnt, status, level, lives, timer, level_start,
                     6'(e.status), e.level, e.lives, e.timer, e.ls);
        end
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the model's view of the result.
    task automatic step(input bit rst_n, input logic [7:0] key,
                        input bit tick, input bit clr, input bit dead);
        @(negedge Clk);
        Reset_n     = rst_n;
        keycode     = key;
        frame_tick  = tick;
        level_clear = clr;
        player_dead = dead;
        model_step(rst_n, int'(key), tick, clr, dead);
        q.push_back(model_out());
    endtask

    task automatic idle(input int n, input logic [7:0] key);
        for (int i = 0; i < n; i++) step(1'b1, key, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("cycle", e);
            end
        end
    end

    initial begin : driver
        logic [7:0] key;
        model_reset();
        #2 Reset_n = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Start edge: PLAY, level_start for one cycle
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        idle(2, 8'h00);

        // Held Enter through clear: LEVEL_DONE persists until a fresh edge
        step(1'b1, K_START, 1'b0, 1'b1, 1'b0);
        idle(3, K_START);
        idle(1, 8'h00);
        idle(2, K_START);

        // Timeouts: three expiries at level 1 lead to LOSE
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < TIME_LIMIT; t++) step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
            idle(2, 8'h00);
        end
        idle(1, K_START);

        // Priority: clear+dead at last level gives WIN with lives intact
        idle(1, 8'h00);
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        idle(1, 8'h00);

        // Pause: events frozen, resume without level_start, quit from pause
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, K_PAUSE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h00, 1'b1, 1'b0, (i == 4));
        step(1'b1, K_PAUSE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, K_PAUSE, 1'b0, 1'b0, 1'b0);
        step(1'b1, K_QUIT, 1'b0, 1'b0, 1'b0);
        idle(1, 8'h00);

        // Reach level 1 with one life, then async reset while level_start is high
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, K_START, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        model_reset();
        compare("async_reset", model_out());
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Random traffic
        key = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: key = 8'h00;
                    4, 5:       key = K_START;
                    6, 7:       key = K_PAUSE;
                    8:          key = K_QUIT;
                    default:    key = 8'($urandom_range(1, 255));
                endcase
            end
            step(($urandom_range(0, 499) != 0), key,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 29) == 0));
        end

        @(posedge Clk);
        #2;
        if (q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drain: got %0d pending entries, exp 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised multi-level game-flow controller; successor to the single-round status FSM.
- Sequences title → play → level-complete → win/lose, with pause, per-level countdown timer, life counter and level index.
- Consumes the USB keycode plus gameplay event pulses from the sprite/collision logic; drives one-hot status to the colour mapper and level/lives/timer to the HUD and map ROM.

Parameters:
- NUM_LEVELS, 3, number of levels; level index runs 0..NUM_LEVELS-1.
- NUM_LIVES, 3, lives granted at game start.
- TIME_LIMIT, 1800, frame ticks per level attempt (30 s at 60 Hz).
- KEY_START, 8'h28, Enter keycode: start / continue / return.
- KEY_PAUSE, 8'h13, P keycode: pause toggle.
- KEY_QUIT, 8'h29, Esc keycode: quit to title from pause.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  current keycode from keyboard interface; 8'h00 = none.
- frame_tick  in  1  one-Clk pulse per frame (vsync edge, generated upstream).
- level_clear  in  1  one-Clk pulse: player reached the exit.
- player_dead  in  1  one-Clk pulse: player killed.
- status  out  6  one-hot {PAUSE, LOSE, WIN, LEVEL_DONE, PLAY, TITLE}.
- level  out  LW=max(1,$clog2(NUM_LEVELS))  current level index.
- lives  out  $clog2(NUM_LIVES+1)  remaining lives.
- timer  out  $clog2(TIME_LIMIT+1)  remaining frame ticks.
- level_start  out  1  one-Clk pulse: map/sprite logic must (re)load the level.

Behaviour:
- Reset (async assert, sync release): state TITLE, status 6'b000001, level 0, lives NUM_LIVES, timer TIME_LIMIT, level_start 0, prev_key 8'h00.
- Key edges: prev_key registers keycode every cycle; edge(K) = (keycode==K) && (prev_key!=K). A held key never retriggers; only edges advance the FSM.
- All outputs are registered; status reflects the current state, 0-cycle decode from the state register.
- TITLE: edge(KEY_START) → PLAY; level←0, lives←NUM_LIVES, timer←TIME_LIMIT, level_start=1 for the next cycle.
- PLAY, evaluated in priority order, one action per cycle:
  1. level_clear: if level==NUM_LEVELS-1 → WIN, else → LEVEL_DONE. Timer frozen.
  2. player_dead, or timer==0: lives←lives-1. If lives==1 → LOSE (lives reads 0). Otherwise stay in PLAY, timer←TIME_LIMIT, level_start pulse.
  3. edge(KEY_PAUSE) → PAUSE.
  4. Otherwise frame_tick with timer>0: timer←timer-1.
- Timer behaviour in PLAY: timer reaching 0 costs exactly one life, on the cycle after it reads 0; it never underflows.
- PAUSE:
  - Timer and all counters frozen; level_clear, player_dead and frame_tick are ignored.
  - edge(KEY_PAUSE) → PLAY, no level_start.
  - edge(KEY_QUIT) → TITLE.
  - If both edges occur in the same cycle, KEY_QUIT wins.
- LEVEL_DONE: edge(KEY_START) → PLAY; level←level+1, timer←TIME_LIMIT, level_start pulse. Lives are kept.
- WIN, LOSE: edge(KEY_START) → TITLE. level, lives and timer hold their values for HUD display until the next start.
- level_start: asserted exactly one cycle, the cycle after the transition/reload decision. It never asserts outside PLAY entry or a life-loss restart.
- Event pulses arriving in TITLE, LEVEL_DONE, WIN or LOSE are ignored.
- Reset_n assertion mid-game returns immediately to reset values, including clearing a level_start pulse in flight.
- Illegal state encoding → TITLE on the next clock.

Test Plan:
- Reset + start edge: Reset_n low then high, keycode 8'h28 for 1 cycle → status 000010, level 0, lives 3, timer 1800, level_start high for exactly 1 cycle.
- Held key: keycode held at 8'h28 through TITLE→PLAY→(level_clear)→LEVEL_DONE → stays LEVEL_DONE until keycode drops to 00 and returns to 28 → PLAY, level 1.
- Timeout (TIME_LIMIT=4): 4 frame_ticks in PLAY → timer 0, next cycle lives 2, timer 4, level_start pulse. Repeat twice more → LOSE, lives 0.
- Priority: level_clear and player_dead in the same cycle at level 2 → WIN, lives unchanged 3.
- Pause: P edge → PAUSE. 10 frame_ticks plus a player_dead pulse → timer and lives unchanged. P edge → PLAY with no level_start. Esc while paused → TITLE.
- Async reset mid-PLAY at level 1, lives 1: Reset_n low between clock edges → outputs return to reset values immediately, without waiting for Clk.
